// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, iterative unsigned multiply/divide with HI/LO,
// and the EX/MEM pipeline register (bubbled while the MD unit holds EX).
module ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rsdata_ex,
   input  logic [31:0] rtdata_ex,
   input  logic [31:0] extendedimm_ex,
   input  logic [31:0] instr_ex,
   input  logic [3:0]  alucontrol_ex,
   input  logic        alusrc_ex,
   input  logic        regdst_ex,
   input  logic        regwrite_ex,
   input  logic        memtoreg_ex,
   input  logic        memwrite_ex,
   output logic        stall_ex,
   output logic [31:0] aluresult_mem,
   output logic [31:0] writedata_mem,
   output logic [4:0]  writereg_mem,
   output logic        regwrite_mem,
   output logic        memtoreg_mem,
   output logic        memwrite_mem
);
   // state  | meaning
   // IDLE   | no MD op in flight; an MD op here launches the unit
   // BUSY   | one multiply/divide iteration per cycle, 32 total
   // DONE   | HI/LO final; instruction retires, EX released
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_LUI   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLL   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_MULTU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_MFHI  = 4'b1101;
   localparam logic [3:0] OP_MFLO  = 4'b1110;
   localparam logic [3:0] OP_SLTU  = 4'b1111;

   logic [1:0]  r_state;
   logic [4:0]  r_count;
   logic [31:0] r_hi, r_lo;
   logic [31:0] r_upper, r_lower, r_opnd;
   logic        r_is_div;

   logic [31:0] w_b;
   logic [4:0]  w_shamt;
   logic [4:0]  w_writereg;
   logic [31:0] w_result;
   logic        w_md_op;
   logic [32:0] w_mul_sum;
   logic [32:0] w_rem_sh;
   logic [32:0] w_diff;
   logic [31:0] w_next_upper, w_next_lower;

   assign w_b        = alusrc_ex ? extendedimm_ex : rtdata_ex;
   assign w_shamt    = instr_ex[10:6];
   assign w_writereg = regdst_ex ? instr_ex[15:11] : instr_ex[20:16];
   assign w_md_op    = (alucontrol_ex == OP_MULTU) || (alucontrol_ex == OP_DIVU);
   assign stall_ex   = !reset && (((r_state == S_IDLE) && w_md_op) || (r_state == S_BUSY));

   always_comb begin
      w_result = 32'd0;
      case (alucontrol_ex)
         OP_AND:  w_result = rsdata_ex & w_b;
         OP_OR:   w_result = rsdata_ex | w_b;
         OP_ADD:  w_result = rsdata_ex + w_b;
         OP_XOR:  w_result = rsdata_ex ^ w_b;
         OP_NOR:  w_result = ~(rsdata_ex | w_b);
         OP_LUI:  w_result = {w_b[15:0], 16'h0000};
         OP_SUB:  w_result = rsdata_ex - w_b;
         OP_SLT:  w_result = {31'd0, $signed(rsdata_ex) < $signed(w_b)};
         OP_SLTU: w_result = {31'd0, rsdata_ex < w_b};
         OP_SLL:  w_result = w_b << w_shamt;
         OP_SRL:  w_result = w_b >> w_shamt;
         OP_SRA:  w_result = $unsigned($signed(w_b) >>> w_shamt);
         OP_MFHI: w_result = r_hi;
         OP_MFLO: w_result = r_lo;
         default: w_result = 32'd0;
      endcase
   end

   // Multiply: {upper,lower} is the shifting product with the multiplier in lower.
   // Divide: upper is the partial remainder, lower shifts dividend out / quotient in.
   // A zero divisor never borrows, which yields remainder = A and quotient = all ones.
   always_comb begin
      w_mul_sum = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : 33'd0);
      w_rem_sh  = {r_upper, r_lower[31]};
      w_diff    = w_rem_sh - {1'b0, r_opnd};
      if (r_is_div) begin
         if (!w_diff[32]) begin
            w_next_upper = w_diff[31:0];
            w_next_lower = {r_lower[30:0], 1'b1};
         end else begin
            w_next_upper = w_rem_sh[31:0];
            w_next_lower = {r_lower[30:0], 1'b0};
         end
      end else begin
         w_next_upper = w_mul_sum[32:1];
         w_next_lower = {w_mul_sum[0], r_lower[31:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= 5'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_upper  <= 32'd0;
         r_lower  <= 32'd0;
         r_opnd   <= 32'd0;
         r_is_div <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_md_op) begin
                  r_state  <= S_BUSY;
                  r_count  <= 5'd0;
                  r_is_div <= (alucontrol_ex == OP_DIVU);
                  r_upper  <= 32'd0;
                  r_lower  <= (alucontrol_ex == OP_DIVU) ? rsdata_ex : w_b;
                  r_opnd   <= (alucontrol_ex == OP_DIVU) ? w_b : rsdata_ex;
               end
            end
            S_BUSY: begin
               r_upper <= w_next_upper;
               r_lower <= w_next_lower;
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_state <= S_DONE;
                  r_hi    <= w_next_upper;
                  r_lo    <= w_next_lower;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || stall_ex) begin
         aluresult_mem <= 32'd0;
         writedata_mem <= 32'd0;
         writereg_mem  <= 5'd0;
         regwrite_mem  <= 1'b0;
         memtoreg_mem  <= 1'b0;
         memwrite_mem  <= 1'b0;
      end else begin
         aluresult_mem <= w_result;
         writedata_mem <= rtdata_ex;
         writereg_mem  <= w_writereg;
         regwrite_mem  <= regwrite_ex;
         memtoreg_mem  <= memtoreg_ex;
         memwrite_mem  <= memwrite_ex;
      end
   end
endmodule
